// File: rtl/sensor_spi_pkg.sv
// -----------------------------------------------------------------------------
// sensor_spi_pkg
// Shared definitions for the sensor-packet SPI link. Both the master
// transmitter and the slave receiver import this package so that the two
// ends agree on the byte layout of a packet.
//   - HEADER_BYTE, PACKET_SIZE, PACKET_BITS : framing constants
//   - *_IDX                                 : byte offsets inside a packet
//   - FLAG_*                                : bit positions in the flags byte
//   - spi_state_e                           : master FSM state encoding
//   - build_packet()                        : assembles the 128-bit packet
// -----------------------------------------------------------------------------
package sensor_spi_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hAA;
    localparam int         PACKET_SIZE = 16;
    localparam int         PACKET_BITS = 128;

    localparam int ROLL_IDX  = 1;
    localparam int PITCH_IDX = 3;
    localparam int YAW_IDX   = 5;
    localparam int GX_IDX    = 7;
    localparam int GY_IDX    = 9;
    localparam int GZ_IDX    = 11;
    localparam int FLAGS_IDX = 13;
    localparam int RSVD_IDX  = 14;

    localparam int FLAG_EULER = 0;
    localparam int FLAG_GYRO  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_e;

    typedef logic [PACKET_BITS-1:0] packet_t;

    // Byte 0 of the packet occupies the top eight bits so that a plain
    // MSB-first shift sends the header first. 16-bit fields go high byte first.
    function automatic packet_t build_packet(
        input logic [15:0] roll,
        input logic [15:0] pitch,
        input logic [15:0] yaw,
        input logic [15:0] gyro_x,
        input logic [15:0] gyro_y,
        input logic [15:0] gyro_z,
        input logic        euler_valid,
        input logic        gyro_valid
    );
        logic [7:0] bytes [PACKET_SIZE];
        packet_t    pkt;
        for (int k = 0; k < PACKET_SIZE; k++) begin
            bytes[k] = 8'h00;
        end
        bytes[0]             = HEADER_BYTE;
        bytes[ROLL_IDX]      = roll[15:8];
        bytes[ROLL_IDX + 1]  = roll[7:0];
        bytes[PITCH_IDX]     = pitch[15:8];
        bytes[PITCH_IDX + 1] = pitch[7:0];
        bytes[YAW_IDX]       = yaw[15:8];
        bytes[YAW_IDX + 1]   = yaw[7:0];
        bytes[GX_IDX]        = gyro_x[15:8];
        bytes[GX_IDX + 1]    = gyro_x[7:0];
        bytes[GY_IDX]        = gyro_y[15:8];
        bytes[GY_IDX + 1]    = gyro_y[7:0];
        bytes[GZ_IDX]        = gyro_z[15:8];
        bytes[GZ_IDX + 1]    = gyro_z[7:0];
        bytes[FLAGS_IDX][FLAG_EULER] = euler_valid;
        bytes[FLAGS_IDX][FLAG_GYRO]  = gyro_valid;
        bytes[RSVD_IDX]      = 8'h00;
        bytes[RSVD_IDX + 1]  = 8'h00;
        pkt = '0;
        for (int k = 0; k < PACKET_SIZE; k++) begin
            pkt[PACKET_BITS - 1 - 8 * k -: 8] = bytes[k];
        end
        return pkt;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Loadable down-counter. Loading N-1 makes tick rise during the N-th cycle
// after the load edge, so the owner can advance exactly N cycles later.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : load load_value on the next clock edge
//   load_value : cycles-minus-one until the next tick
//   tick       : count has reached zero (terminal count)
// -----------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tick
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/sensor_packet_spi_master.sv
// -----------------------------------------------------------------------------
// sensor_packet_spi_master
// SPI Mode 0, MSB-first transmitter for one 16-byte sensor packet per start.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   start               : transfer request, sampled only in IDLE
//   roll, pitch, yaw    : Euler angles x100 (signed)
//   gyro_x/y/z          : gyro rates x2000 (signed)
//   euler_valid         : flags bit 0
//   gyro_valid          : flags bit 1
//   busy                : high from the accept edge until done
//   done                : one-cycle pulse at the end of the transfer
//   cs_n, sck, sdo      : SPI bus (sck idles low)
// Frame: SETUP (CS_SETUP) -> 128 bits of CLK_DIV low + CLK_DIV high ->
//        HOLD (CS_HOLD) -> GAP (CS_GAP, cs_n high) -> IDLE with done.
// -----------------------------------------------------------------------------
module sensor_packet_spi_master
    import sensor_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] pitch,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    input  logic               euler_valid,
    input  logic               gyro_valid,
    output logic               busy,
    output logic               done,
    output logic               cs_n,
    output logic               sck,
    output logic               sdo
);

    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CD  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int PH_W    = $clog2(MAX_CNT + 1);

    localparam logic [PH_W-1:0] LD_SETUP = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] LD_HALF  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] LD_HOLD  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0] LD_GAP   = PH_W'(CS_GAP - 1);
    localparam logic [6:0]      LAST_BIT = 7'(PACKET_BITS - 1);

    spi_state_e      state_q, state_d;
    packet_t         shift_q, shift_d;
    packet_t         packet_in;
    logic [6:0]      bit_cnt_q, bit_cnt_d;
    logic            cs_n_d, sck_d, sdo_d, busy_d, done_d;
    logic            timer_load;
    logic [PH_W-1:0] timer_value;
    logic            tick;

    assign packet_in = build_packet(roll, pitch, yaw, gyro_x, gyro_y, gyro_z,
                                    euler_valid, gyro_valid);

    spi_phase_timer #(
        .WIDTH(PH_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (tick)
    );

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cs_n_d      = cs_n;
        sck_d       = sck;
        sdo_d       = sdo;
        busy_d      = busy;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETUP;
                    shift_d     = packet_in;
                    bit_cnt_d   = '0;
                    cs_n_d      = 1'b0;
                    sck_d       = 1'b0;
                    sdo_d       = packet_in[PACKET_BITS-1];
                    busy_d      = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = LD_SETUP;
                end
            end

            SETUP: begin
                // First bit is already on sdo; the first low phase starts now.
                if (tick) begin
                    state_d     = XFER;
                    timer_load  = 1'b1;
                    timer_value = LD_HALF;
                end
            end

            XFER: begin
                if (tick) begin
                    timer_load  = 1'b1;
                    timer_value = LD_HALF;
                    if (!sck) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling edge: the next bit goes out on this same edge,
                        // giving the slave a full low phase of setup time.
                        sck_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d     = HOLD;
                            timer_value = LD_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                            shift_d   = {shift_q[PACKET_BITS-2:0], 1'b0};
                            sdo_d     = shift_q[PACKET_BITS-2];
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    state_d     = GAP;
                    cs_n_d      = 1'b1;
                    sdo_d       = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = LD_GAP;
                end
            end

            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            // NOTE: the shift buffer holds data, not control; it is reset
            // anyway so it never carries X between reset and the first accept.
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cs_n      <= cs_n_d;
            sck       <= sck_d;
            sdo       <= sdo_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// -----------------------------------------------------------------------------
// tb_sensor_packet_spi_master
// Three masters share clock, reset and data inputs: instance 0 uses the
// default timing, instance 1 CLK_DIV=1 and instance 2 CLK_DIV=7 (other
// timings 1). A Mode-0 slave monitor per instance captures sdo on sck rising
// edges and measures phase lengths; a byte-queue reference model supplies
// the expected packets.
// -----------------------------------------------------------------------------
module tb_sensor_packet_spi_master;

    localparam int NI = 3;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 7;
    endfunction
    function automatic int setup_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int hold_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int gap_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NI-1:0]     start = '0;
    logic signed [15:0] roll = '0, pitch = '0, yaw = '0;
    logic signed [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic              euler_valid = 1'b0, gyro_valid = 1'b0;
    wire  [NI-1:0]     busy, done, cs_n, sck, sdo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sensor_packet_spi_master #(
            .CLK_DIV  (div_of(g)),
            .CS_SETUP (setup_of(g)),
            .CS_HOLD  (hold_of(g)),
            .CS_GAP   (gap_of(g))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start[g]),
            .roll        (roll),
            .pitch       (pitch),
            .yaw         (yaw),
            .gyro_x      (gyro_x),
            .gyro_y      (gyro_y),
            .gyro_z      (gyro_z),
            .euler_valid (euler_valid),
            .gyro_valid  (gyro_valid),
            .busy        (busy[g]),
            .done        (done[g]),
            .cs_n        (cs_n[g]),
            .sck         (sck[g]),
            .sdo         (sdo[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packet: header, six 16-bit fields high byte first, flags,
    // two reserved zero bytes; byte 0 is transmitted first.
    function automatic logic [127:0] model_packet(
        input logic [15:0] r, input logic [15:0] p, input logic [15:0] y,
        input logic [15:0] gx, input logic [15:0] gy, input logic [15:0] gz,
        input logic ev, input logic gv);
        logic [7:0]   q[$];
        logic [15:0]  f[6];
        logic [127:0] pkt;
        f[0] = r; f[1] = p; f[2] = y; f[3] = gx; f[4] = gy; f[5] = gz;
        q.push_back(8'hAA);
        for (int k = 0; k < 6; k++) begin
            q.push_back(f[k][15:8]);
            q.push_back(f[k][7:0]);
        end
        q.push_back({6'b0, gv, ev});
        q.push_back(8'h00);
        q.push_back(8'h00);
        pkt = '0;
        foreach (q[k]) pkt = {pkt[119:0], q[k]};
        return pkt;
    endfunction

    // ---------------- Mode-0 slave monitor, one per instance ----------------
    logic         p_cs   [NI] = '{default: 1'b1};
    logic         p_sck  [NI] = '{default: 1'b0};
    logic         p_sdo  [NI] = '{default: 1'b0};
    bit           m_in   [NI] = '{default: 1'b0};
    bit           m_first[NI] = '{default: 1'b0};
    int           m_rises[NI] = '{default: 0};
    int           m_len  [NI] = '{default: 0};
    int           m_gap  [NI] = '{default: 0};
    int           m_last_gap[NI] = '{default: 0};
    int           m_frames[NI] = '{default: 0};
    int           m_dones[NI] = '{default: 0};
    int           m_bad_hi[NI] = '{default: 0};
    int           m_bad_lo[NI] = '{default: 0};
    int           m_bad_sdo[NI] = '{default: 0};
    int           m_idle_bad[NI] = '{default: 0};
    logic [127:0] m_shift[NI] = '{default: '0};
    logic [127:0] m_frame[NI] = '{default: '0};

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_in[i] = 1'b0;
            end else if (p_cs[i] && !cs_n[i]) begin
                m_in[i]       = 1'b1;
                m_first[i]    = 1'b1;
                m_rises[i]    = 0;
                m_len[i]      = 1;
                m_bad_hi[i]   = 0;
                m_bad_lo[i]   = 0;
                m_bad_sdo[i]  = 0;
                m_shift[i]    = '0;
                m_last_gap[i] = m_gap[i];
            end else if (!cs_n[i] && m_in[i]) begin
                if (sck[i] && !p_sck[i]) begin
                    m_rises[i]++;
                    m_shift[i] = {m_shift[i][126:0], sdo[i]};
                    if (sdo[i] !== p_sdo[i]) m_bad_sdo[i]++;
                    if (m_len[i] != (m_first[i] ? setup_of(i) + div_of(i) : div_of(i)))
                        m_bad_lo[i]++;
                    m_first[i] = 1'b0;
                    m_len[i]   = 1;
                end else if (!sck[i] && p_sck[i]) begin
                    if (m_len[i] != div_of(i)) m_bad_hi[i]++;
                    m_len[i] = 1;
                end else begin
                    m_len[i]++;
                    if (sdo[i] !== p_sdo[i]) m_bad_sdo[i]++;
                end
            end else if (cs_n[i] && !p_cs[i] && m_in[i]) begin
                m_in[i] = 1'b0;
                m_frame[i] = m_shift[i];
                m_frames[i]++;
                check($sformatf("dut%0d_rising_edges", i), m_rises[i], 128);
                check($sformatf("dut%0d_high_phase_errs", i), m_bad_hi[i], 0);
                check($sformatf("dut%0d_low_phase_errs", i), m_bad_lo[i], 0);
                check($sformatf("dut%0d_sdo_change_errs", i), m_bad_sdo[i], 0);
                check($sformatf("dut%0d_hold_len", i), m_len[i], hold_of(i));
            end
            if (cs_n[i]) begin
                if (!p_cs[i]) m_gap[i] = 1;
                else m_gap[i]++;
                if (sck[i] === 1'b1 || sdo[i] === 1'b1) m_idle_bad[i]++;
            end
            if (done[i] === 1'b1) m_dones[i]++;
            p_cs[i]  = cs_n[i];
            p_sck[i] = sck[i];
            p_sdo[i] = sdo[i];
        end
    end

    // ------------------------------- stimulus --------------------------------
    task automatic randomize_inputs();
        roll        = 16'($urandom);
        pitch       = 16'($urandom);
        yaw         = 16'($urandom);
        gyro_x      = 16'($urandom);
        gyro_y      = 16'($urandom);
        gyro_z      = 16'($urandom);
        euler_valid = 1'($urandom);
        gyro_valid  = 1'($urandom);
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        @(negedge clk); #1;
        while (busy[idx] && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("dut%0d_idle_wait", idx), busy[idx], 1'b0);
    endtask

    // One complete transfer; returns the frame the slave monitor captured.
    task automatic run_packet(input int idx, input bit storm, input bit scramble,
                              output logic [127:0] got);
        logic [127:0] exp;
        int n, lim, exp_n, f0, d0;
        exp   = model_packet(roll, pitch, yaw, gyro_x, gyro_y, gyro_z, euler_valid, gyro_valid);
        exp_n = setup_of(idx) + 256 * div_of(idx) + hold_of(idx) + gap_of(idx);
        lim   = 2 * exp_n + 50;
        wait_idle(idx);
        f0 = m_frames[idx];
        d0 = m_dones[idx];
        start[idx] = 1'b1;
        @(negedge clk); #1;
        start[idx] = 1'b0;
        if (scramble) randomize_inputs();
        n = 0;
        while (busy[idx] && n < lim) begin
            n++;
            if (storm) start[idx] = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
        end
        start[idx] = 1'b0;
        check($sformatf("dut%0d_busy_cycles", idx), n, exp_n);
        check($sformatf("dut%0d_done_at_end", idx), done[idx], 1'b1);
        check($sformatf("dut%0d_frame", idx), m_frame[idx], exp);
        check($sformatf("dut%0d_frame_count", idx), m_frames[idx], f0 + 1);
        check($sformatf("dut%0d_done_count", idx), m_dones[idx], d0 + 1);
        got = m_frame[idx];
        @(negedge clk); #1;
        check($sformatf("dut%0d_done_single", idx), done[idx], 1'b0);
        check($sformatf("dut%0d_no_restart", idx), busy[idx], 1'b0);
    endtask

    initial begin
        logic [127:0] got, exp_a, exp_b;
        int n, f0, d0;

        // Reset state on every instance.
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {cs_n, sck, sdo, busy, done}, {3'b111, 12'b0});
        rst_n = 1'b1;

        // Directed packet from the reference example.
        roll = 16'h1234; pitch = 16'hFF9C; yaw = 16'h0001;
        gyro_x = 16'h07D0; gyro_y = 16'h8000; gyro_z = 16'h7FFF;
        euler_valid = 1'b1; gyro_valid = 1'b1;
        run_packet(0, 1'b0, 1'b0, got);
        check("directed_bytes", got, 128'hAA1234FF9C000107D080007FFF030000);

        // Flag combinations and reserved bytes.
        randomize_inputs();
        euler_valid = 1'b0; gyro_valid = 1'b1;
        run_packet(0, 1'b0, 1'b0, got);
        check("flags_gyro_only", got[23:16], 8'h02);
        check("reserved_a", got[15:0], 16'h0000);
        randomize_inputs();
        euler_valid = 1'b0; gyro_valid = 1'b0;
        run_packet(0, 1'b0, 1'b0, got);
        check("flags_none", got[23:16], 8'h00);
        check("reserved_b", got[15:0], 16'h0000);

        // start toggled randomly while busy is neither queued nor restarting.
        randomize_inputs();
        run_packet(0, 1'b1, 1'b0, got);
        f0 = m_frames[0];
        repeat (30) @(negedge clk);
        #1;
        check("storm_stays_idle", busy[0], 1'b0);
        check("storm_no_extra_frame", m_frames[0], f0);

        // start held through done: back-to-back packets. The bus stays high
        // for the CS_GAP cycles plus the IDLE (done) cycle that samples start.
        wait_idle(0);
        randomize_inputs();
        exp_a = model_packet(roll, pitch, yaw, gyro_x, gyro_y, gyro_z, euler_valid, gyro_valid);
        d0 = m_dones[0];
        start[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done[0] && n < 3000);
        check("b2b_first_done", done[0], 1'b1);
        check("b2b_first_frame", m_frame[0], exp_a);
        randomize_inputs();
        exp_b = model_packet(roll, pitch, yaw, gyro_x, gyro_y, gyro_z, euler_valid, gyro_valid);
        @(negedge clk); #1;
        start[0] = 1'b0;
        check("b2b_second_accept", busy[0], 1'b1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done[0] && n < 3000);
        check("b2b_second_done", done[0], 1'b1);
        check("b2b_second_frame", m_frame[0], exp_b);
        check("b2b_gap_cycles", m_last_gap[0], gap_of(0) + 1);
        check("b2b_done_count", m_dones[0], d0 + 2);

        // Asynchronous reset at bit 50, then a clean packet.
        wait_idle(0);
        randomize_inputs();
        start[0] = 1'b1;
        @(negedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        while (m_rises[0] < 50 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("reset_reached_bit50", m_rises[0], 50);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_bus", {cs_n[0], sck[0], sdo[0], busy[0]}, 4'b1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("no_resume_after_reset", {cs_n[0], busy[0]}, 2'b10);
        randomize_inputs();
        run_packet(0, 1'b0, 1'b0, got);

        // Inputs scrambled right after accept; frame must hold latched values.
        randomize_inputs();
        run_packet(0, 1'b0, 1'b1, got);

        // Random packets on every timing variant.
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 2; k++) begin
                randomize_inputs();
                run_packet(i, 1'b0, (k == 1), got);
            end
        end

        for (int i = 0; i < NI; i++) begin
            check($sformatf("dut%0d_idle_bus", i), m_idle_bad[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
